// File: rtl/spi_cfg_pkg.sv
// Shared widths, state encoding and boot-table entry type for the SPI config sequencer.
package spi_cfg_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 8;

  typedef enum logic [2:0] {
    ST_WAIT    = 3'd0,
    ST_B_ISSUE = 3'd1,
    ST_B_WAIT  = 3'd2,
    ST_READY   = 3'd3,
    ST_H_WAIT  = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } boot_entry_t;

endpackage

// File: rtl/spi_cfg_rom.sv
// ADC power-up register sequence, indexed by boot-table position.
module spi_cfg_rom
  import spi_cfg_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output boot_entry_t      entry
);

  // Fixed lookup; entries beyond the table read as a harmless write of 0 to address 0.
  always_comb begin
    entry = '0;
    case (idx)
      8'd0:    entry = '{addr: 13'h000, data: 8'h18}; // interface config: SDO active, MSB first
      8'd1:    entry = '{addr: 13'h008, data: 8'h00}; // power mode: normal operation
      8'd2:    entry = '{addr: 13'h009, data: 8'h01}; // clock: duty-cycle stabilizer on
      8'd3:    entry = '{addr: 13'h00B, data: 8'h00}; // clock divider: divide by 1
      8'd4:    entry = '{addr: 13'h00D, data: 8'h00}; // test pattern off
      8'd5:    entry = '{addr: 13'h010, data: 8'h00}; // offset adjust: none
      8'd6:    entry = '{addr: 13'h014, data: 8'h01}; // output format: two's complement
      8'd7:    entry = '{addr: 13'h015, data: 8'h00}; // output drive: default
      8'd8:    entry = '{addr: 13'h016, data: 8'h00}; // output clock phase: default
      8'd9:    entry = '{addr: 13'h017, data: 8'h00}; // output delay: none
      8'd10:   entry = '{addr: 13'h018, data: 8'h04}; // input span / vref select
      8'd11:   entry = '{addr: 13'h02E, data: 8'h00}; // output assignment
      8'd12:   entry = '{addr: 13'h030, data: 8'h00}; // features: defaults
      8'd13:   entry = '{addr: 13'h03A, data: 8'h00}; // sync control: disabled
      8'd14:   entry = '{addr: 13'h100, data: 8'h00}; // sample rate override off
      8'd15:   entry = '{addr: 13'h0FF, data: 8'h01}; // transfer: commit shadow registers
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/spi_cfg_sequencer.sv
// Owns the SPI transaction engine: boot-table replay after reset, then shared host access.
module spi_cfg_sequencer
  import spi_cfg_pkg::*;
#(
  parameter int unsigned NUM_CMDS    = 16,
  parameter int unsigned WAIT_CYCLES = 1000,
  parameter int unsigned TIMEOUT     = 4095
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              host_req,
  input  logic              host_rw,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              cfg_restart,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic              spi_start,
  output logic              spi_rw,
  output logic [ADDR_W-1:0] spi_addr,
  output logic [DATA_W-1:0] spi_wdata,
  input  logic              spi_busy,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] spi_rdata
);

  localparam int unsigned WAIT_W = $clog2(WAIT_CYCLES + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CMDS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  seq_state_e        state;
  logic [WAIT_W-1:0] wait_ctr;
  logic [TMO_W-1:0]  tmo_ctr;
  logic [IDX_W-1:0]  idx;
  logic              restart_pend;
  boot_entry_t       rom_entry;

  logic tmo_hit_c;
  logic xfer_end_c;
  logic restart_now_c;

  spi_cfg_rom u_rom (
    .idx   (idx),
    .entry (rom_entry)
  );

  // A real spi_done wins over a timeout landing in the same cycle.
  assign tmo_hit_c     = (tmo_ctr == TMO_LAST) && !spi_done;
  assign xfer_end_c    = spi_done || tmo_hit_c;
  assign restart_now_c = restart_pend || cfg_restart;

  // Sequencer FSM with registered engine/host outputs.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state        <= ST_WAIT;
      wait_ctr     <= '0;
      tmo_ctr      <= '0;
      idx          <= '0;
      restart_pend <= 1'b0;
      host_ack     <= 1'b0;
      host_rdata   <= '0;
      cfg_done     <= 1'b0;
      cfg_err      <= 1'b0;
      spi_start    <= 1'b0;
      spi_rw       <= 1'b0;
      spi_addr     <= '0;
      spi_wdata    <= '0;
    end else begin
      spi_start <= 1'b0;
      host_ack  <= 1'b0;

      case (state)
        ST_WAIT: begin
          if (wait_ctr == WAIT_LAST) begin
            state <= ST_B_ISSUE;
          end else begin
            wait_ctr <= wait_ctr + 1'b1;
          end
        end

        ST_B_ISSUE: begin
          // A restart here has nothing in flight, so rewind and issue entry 0 next cycle.
          if (restart_now_c) begin
            idx          <= '0;
            restart_pend <= 1'b0;
          end else if (!spi_busy) begin
            spi_start <= 1'b1;
            spi_rw    <= 1'b0;
            spi_addr  <= rom_entry.addr;
            spi_wdata <= rom_entry.data;
            tmo_ctr   <= '0;
            state     <= ST_B_WAIT;
          end
        end

        ST_B_WAIT: begin
          if (cfg_restart) begin
            restart_pend <= 1'b1;
          end
          if (xfer_end_c) begin
            if (tmo_hit_c) begin
              cfg_err <= 1'b1;
            end
            idx <= idx + 1'b1;
            if (restart_now_c) begin
              idx          <= '0;
              restart_pend <= 1'b0;
              state        <= ST_B_ISSUE;
            end else if (idx == LAST_IDX) begin
              cfg_done <= 1'b1;
              state    <= ST_READY;
            end else begin
              state <= ST_B_ISSUE;
            end
          end else begin
            tmo_ctr <= tmo_ctr + 1'b1;
          end
        end

        ST_READY: begin
          // host_ack high means the requester has not yet dropped host_req for the last ack.
          if (restart_now_c) begin
            cfg_done     <= 1'b0;
            idx          <= '0;
            restart_pend <= 1'b0;
            state        <= ST_B_ISSUE;
          end else if (host_req && !host_ack && !spi_busy) begin
            spi_start <= 1'b1;
            spi_rw    <= host_rw;
            spi_addr  <= host_addr;
            spi_wdata <= host_wdata;
            tmo_ctr   <= '0;
            state     <= ST_H_WAIT;
          end
        end

        ST_H_WAIT: begin
          if (cfg_restart) begin
            restart_pend <= 1'b1;
          end
          if (xfer_end_c) begin
            host_ack <= 1'b1;
            if (tmo_hit_c) begin
              cfg_err    <= 1'b1;
              host_rdata <= '0;
            end else if (spi_rw) begin
              host_rdata <= spi_rdata;
            end
            if (restart_now_c) begin
              cfg_done     <= 1'b0;
              idx          <= '0;
              restart_pend <= 1'b0;
              state        <= ST_B_ISSUE;
            end else begin
              state <= ST_READY;
            end
          end else begin
            tmo_ctr <= tmo_ctr + 1'b1;
          end
        end

        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Directed bench for spi_cfg_sequencer with a behavioural 20-cycle SPI engine model.
module tb_spi_cfg_sequencer;
  import spi_cfg_pkg::*;

  localparam int unsigned NUM_CMDS    = 4;
  localparam int unsigned WAIT_CYCLES = 10;
  localparam int unsigned TIMEOUT     = 50;

  logic              sys_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              host_req = 1'b0;
  logic              host_rw = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              cfg_restart = 1'b0;
  logic              cfg_done;
  logic              cfg_err;
  logic              spi_start;
  logic              spi_rw;
  logic [ADDR_W-1:0] spi_addr;
  logic [DATA_W-1:0] spi_wdata;
  logic              spi_busy = 1'b0;
  logic              spi_done = 1'b0;
  logic [DATA_W-1:0] spi_rdata = '0;

  always #5 sys_clk = ~sys_clk;

  spi_cfg_sequencer #(
    .NUM_CMDS    (NUM_CMDS),
    .WAIT_CYCLES (WAIT_CYCLES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .sys_clk     (sys_clk),
    .reset_n     (reset_n),
    .host_req    (host_req),
    .host_rw     (host_rw),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .cfg_restart (cfg_restart),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err),
    .spi_start   (spi_start),
    .spi_rw      (spi_rw),
    .spi_addr    (spi_addr),
    .spi_wdata   (spi_wdata),
    .spi_busy    (spi_busy),
    .spi_done    (spi_done),
    .spi_rdata   (spi_rdata)
  );

  // First four entries of the ADC power-up table
  logic [ADDR_W-1:0] exp_addr [NUM_CMDS] = '{13'h000, 13'h008, 13'h009, 13'h00B};
  logic [DATA_W-1:0] exp_data [NUM_CMDS] = '{8'h18, 8'h00, 8'h01, 8'h00};

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int ack_cnt   = 0;
  int viol_cnt  = 0;

  logic              log_rw   [$];
  logic [ADDR_W-1:0] log_addr [$];
  logic [DATA_W-1:0] log_data [$];

  bit                hang_mode = 1'b0;
  int                eng_cnt   = 0;
  logic [ADDR_W-1:0] eng_addr  = '0;

  // Engine model: busy for 20 cycles after a start, then a done pulse with rdata = addr[7:0]^A5.
  // It ignores reset_n so that an abandoned transaction still completes.
  always @(posedge sys_clk) begin
    spi_done <= 1'b0;
    if (spi_start && !spi_busy) begin
      spi_busy <= 1'b1;
      eng_cnt  <= 20;
      eng_addr <= spi_addr;
    end else if (spi_busy) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        spi_busy <= 1'b0;
        if (!hang_mode) begin
          spi_done  <= 1'b1;
          spi_rdata <= eng_addr[7:0] ^ 8'hA5;
        end
      end
    end
  end

  // Record issued transactions, acks and starts that collide with a busy engine.
  always @(posedge sys_clk) begin
    cyc = cyc + 1;
    if (spi_start) begin
      log_rw.push_back(spi_rw);
      log_addr.push_back(spi_addr);
      log_data.push_back(spi_wdata);
      if (spi_busy) viol_cnt = viol_cnt + 1;
    end
    if (host_ack) ack_cnt = ack_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1);
  end

  task automatic clear_log();
    log_rw.delete();
    log_addr.delete();
    log_data.delete();
    ack_cnt = 0;
  endtask

  task automatic wait_cfg_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge sys_clk); #1;
      if (cfg_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_host_ack(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge sys_clk); #1;
      if (host_ack) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_spi_start(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge sys_clk); #1;
      if (spi_start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [33:0] outv;
    reset_n = 1'b0; host_req = 1'b0; cfg_restart = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    outv = {spi_start, spi_rw, spi_addr, spi_wdata, host_ack, host_rdata, cfg_done, cfg_err};
    total_cnt++;
    if (outv !== 34'd0) $display("FAIL reset_outputs: got %h expected 0", outv);
    else pass_cnt++;
  endtask

  task automatic test_boot();
    int n;
    bit ok;
    clear_log();
    reset_n = 1'b1;
    n = -1;
    for (int i = 1; i <= int'(WAIT_CYCLES) + 20; i++) begin
      @(posedge sys_clk); #1;
      if (spi_start) begin n = i; break; end
    end
    // Edge 1 is the release edge; start is seen WAIT_CYCLES edges after it.
    total_cnt++;
    if (n != int'(WAIT_CYCLES) + 1) $display("FAIL boot_first_start: got edge %0d expected %0d", n, WAIT_CYCLES + 1);
    else pass_cnt++;

    wait_cfg_done(400, ok);
    total_cnt++;
    if (!ok || log_addr.size() != NUM_CMDS)
      $display("FAIL boot_done: done=%0b writes=%0d expected done=1 writes=%0d", ok, log_addr.size(), NUM_CMDS);
    else pass_cnt++;

    for (int i = 0; i < int'(NUM_CMDS); i++) begin
      if (i < int'(log_addr.size())) begin
        total_cnt++;
        if ({log_rw[i], log_addr[i], log_data[i]} !== {1'b0, exp_addr[i], exp_data[i]})
          $display("FAIL boot_entry%0d: got rw=%0b addr=%h data=%h expected rw=0 addr=%h data=%h",
                   i, log_rw[i], log_addr[i], log_data[i], exp_addr[i], exp_data[i]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_host_read();
    int done_cyc;
    int ack_cyc;
    bit got;
    clear_log();
    host_rw = 1'b1; host_addr = 13'h001; host_wdata = 8'h00; host_req = 1'b1;
    @(posedge sys_clk); #1;
    total_cnt++;
    if ({spi_start, spi_rw, spi_addr} !== {1'b1, 1'b1, 13'h001})
      $display("FAIL host_start_latency: got start=%0b rw=%0b addr=%h expected 1 1 001", spi_start, spi_rw, spi_addr);
    else pass_cnt++;

    done_cyc = -100; ack_cyc = -1; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge sys_clk); #1;
      if (spi_done) done_cyc = cyc;
      if (host_ack) begin ack_cyc = cyc; got = 1'b1; break; end
    end
    total_cnt++;
    if (!got || ack_cyc != done_cyc + 1)
      $display("FAIL host_ack_latency: got ack=%0b at %0d expected 1 at %0d", got, ack_cyc, done_cyc + 1);
    else pass_cnt++;

    total_cnt++;
    if (host_rdata !== 8'hA4) $display("FAIL host_rdata: got %h expected a4", host_rdata);
    else pass_cnt++;

    // host_req still high on the cycle after ack; must not start a second transaction.
    @(posedge sys_clk); #1;
    host_req = 1'b0;
    total_cnt++;
    if (host_ack !== 1'b0) $display("FAIL host_ack_width: got %0b expected 0", host_ack);
    else pass_cnt++;

    repeat (30) @(posedge sys_clk);
    #1;
    total_cnt++;
    if (log_addr.size() != 1 || ack_cnt != 1)
      $display("FAIL host_single: got starts=%0d acks=%0d expected 1 1", log_addr.size(), ack_cnt);
    else pass_cnt++;
  endtask

  task automatic test_host_during_boot();
    bit ok;
    reset_n = 1'b0;
    @(posedge sys_clk); #1;
    clear_log();
    host_rw = 1'b0; host_addr = 13'h055; host_wdata = 8'h3C; host_req = 1'b1;
    reset_n = 1'b1;

    wait_cfg_done(600, ok);
    total_cnt++;
    if (!ok || log_addr.size() != NUM_CMDS)
      $display("FAIL boot_blocks_host: done=%0b starts=%0d expected done=1 starts=%0d", ok, log_addr.size(), NUM_CMDS);
    else pass_cnt++;

    wait_host_ack(200, ok);
    @(posedge sys_clk); #1;
    host_req = 1'b0;
    repeat (40) @(posedge sys_clk);
    #1;
    total_cnt++;
    if (!ok || ack_cnt != 1) $display("FAIL boot_host_acks: got ack=%0b count=%0d expected 1 1", ok, ack_cnt);
    else pass_cnt++;

    total_cnt++;
    if (log_addr.size() != NUM_CMDS + 1 ||
        {log_rw[NUM_CMDS], log_addr[NUM_CMDS], log_data[NUM_CMDS]} !== {1'b0, 13'h055, 8'h3C})
      $display("FAIL boot_host_write: got starts=%0d expected %0d with rw=0 addr=055 data=3c", log_addr.size(), NUM_CMDS + 1);
    else pass_cnt++;

    // Write leaves host_rdata at its post-reset value.
    total_cnt++;
    if (host_rdata !== 8'h00) $display("FAIL write_rdata_hold: got %h expected 00", host_rdata);
    else pass_cnt++;
  endtask

  task automatic test_restart_h_wait();
    bit ok;
    clear_log();
    host_rw = 1'b1; host_addr = 13'h010; host_req = 1'b1;
    @(posedge sys_clk); #1;
    repeat (5) @(posedge sys_clk);
    #1;
    cfg_restart = 1'b1;
    @(posedge sys_clk); #1;
    cfg_restart = 1'b0;

    wait_host_ack(200, ok);
    host_req = 1'b0;
    total_cnt++;
    if (!ok) $display("FAIL restart_host_ack: got no ack expected ack");
    else pass_cnt++;
    total_cnt++;
    if (host_rdata !== 8'hB5) $display("FAIL restart_rdata: got %h expected b5", host_rdata);
    else pass_cnt++;
    total_cnt++;
    if (cfg_done !== 1'b0) $display("FAIL restart_done_drop: got %0b expected 0", cfg_done);
    else pass_cnt++;

    clear_log();
    wait_cfg_done(400, ok);
    total_cnt++;
    if (!ok || log_addr.size() != NUM_CMDS)
      $display("FAIL replay_count: done=%0b writes=%0d expected done=1 writes=%0d", ok, log_addr.size(), NUM_CMDS);
    else pass_cnt++;
    for (int i = 0; i < int'(NUM_CMDS); i++) begin
      if (i < int'(log_addr.size())) begin
        total_cnt++;
        if ({log_rw[i], log_addr[i], log_data[i]} !== {1'b0, exp_addr[i], exp_data[i]})
          $display("FAIL replay_entry%0d: got rw=%0b addr=%h data=%h expected rw=0 addr=%h data=%h",
                   i, log_rw[i], log_addr[i], log_data[i], exp_addr[i], exp_data[i]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int start_cyc;
    int err_cyc;
    hang_mode = 1'b1;
    cfg_restart = 1'b1;
    @(posedge sys_clk); #1;
    cfg_restart = 1'b0;
    clear_log();

    wait_spi_start(50, ok);
    start_cyc = cyc;
    err_cyc = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge sys_clk); #1;
      if (cfg_err) begin err_cyc = cyc; break; end
    end
    hang_mode = 1'b0;
    total_cnt++;
    if (!ok || err_cyc - start_cyc != int'(TIMEOUT))
      $display("FAIL timeout_latency: got %0d cycles expected %0d", err_cyc - start_cyc, TIMEOUT);
    else pass_cnt++;

    wait_spi_start(50, ok);
    total_cnt++;
    if (!ok || {spi_addr, spi_wdata} !== {exp_addr[1], exp_data[1]})
      $display("FAIL timeout_advance: got addr=%h data=%h expected addr=%h data=%h", spi_addr, spi_wdata, exp_addr[1], exp_data[1]);
    else pass_cnt++;

    wait_cfg_done(400, ok);
    total_cnt++;
    if (!ok || cfg_err !== 1'b1) $display("FAIL timeout_sticky: got done=%0b err=%0b expected 1 1", ok, cfg_err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [33:0] outv;
    cfg_restart = 1'b1;
    @(posedge sys_clk); #1;
    cfg_restart = 1'b0;
    wait_spi_start(50, ok);
    repeat (5) @(posedge sys_clk);
    #1;
    reset_n = 1'b0;
    @(posedge sys_clk); #1;
    outv = {spi_start, spi_rw, spi_addr, spi_wdata, host_ack, host_rdata, cfg_done, cfg_err};
    reset_n = 1'b1;
    total_cnt++;
    if (!ok || outv !== 34'd0) $display("FAIL reset_mid_outputs: got %h expected 0", outv);
    else pass_cnt++;

    clear_log();
    wait_cfg_done(600, ok);
    total_cnt++;
    if (!ok || log_addr.size() != NUM_CMDS)
      $display("FAIL reset_mid_count: done=%0b writes=%0d expected done=1 writes=%0d", ok, log_addr.size(), NUM_CMDS);
    else pass_cnt++;
    for (int i = 0; i < int'(NUM_CMDS); i++) begin
      if (i < int'(log_addr.size())) begin
        total_cnt++;
        if ({log_rw[i], log_addr[i], log_data[i]} !== {1'b0, exp_addr[i], exp_data[i]})
          $display("FAIL reset_mid_entry%0d: got rw=%0b addr=%h data=%h expected rw=0 addr=%h data=%h",
                   i, log_rw[i], log_addr[i], log_data[i], exp_addr[i], exp_data[i]);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (cfg_err !== 1'b0) $display("FAIL reset_mid_err_clear: got %0b expected 0", cfg_err);
    else pass_cnt++;
  endtask

  task automatic test_no_busy_start();
    total_cnt++;
    if (viol_cnt != 0) $display("FAIL start_while_busy: got %0d expected 0", viol_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_boot();
    test_host_read();
    test_host_during_boot();
    test_restart_h_wait();
    test_timeout();
    test_reset_mid();
    test_no_busy_start();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
